// File: rtl/vpu_dst_port.sv
// Destination port of the vector unit: packs EXEC_CNT lane result beats into one
// SRAM word and issues a single write per instruction, then pulses done_o.
module vpu_dst_port #(
  parameter int EXEC_UNIT_DATA_WIDTH = 256,
  parameter int EXEC_CNT             = 2,
  parameter int SRAM_DATA_WIDTH      = 512,
  parameter int SRAM_ADDR_WIDTH      = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic                            wvalid_i,
  input  logic [SRAM_ADDR_WIDTH-1:0]      waddr_i,
  input  logic                            result_valid_i,
  input  logic [EXEC_UNIT_DATA_WIDTH-1:0] result_data_i,
  output logic                            result_ready_o,
  output logic                            wr_req_o,
  output logic [SRAM_ADDR_WIDTH-1:0]      wr_addr_o,
  output logic [SRAM_DATA_WIDTH-1:0]      wr_data_o,
  input  logic                            wr_gnt_i,
  output logic                            done_o
);

  localparam int CNT_W = (EXEC_CNT > 1) ? $clog2(EXEC_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(EXEC_CNT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic [CNT_W-1:0]            beat_r;
  logic [SRAM_ADDR_WIDTH-1:0]  addr_r;
  logic [SRAM_DATA_WIDTH-1:0]  pack_r;
  logic                        ready_r;
  logic                        req_r;
  logic                        done_r;
  logic                        beat_acc_s;
  logic                        launch_s;

  assign beat_acc_s = (state_r == COLLECT) && result_valid_i;
  assign launch_s   = (state_r == IDLE) && start_i;

  // Next-state decode; start_i and wr_gnt_i only matter in IDLE and WRITE respectively.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_nxt_s = wvalid_i ? COLLECT : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        if (beat_acc_s && (beat_r == LAST_BEAT)) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      WRITE: begin
        if (wr_gnt_i) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs (decoded from the next state).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      beat_r  <= {CNT_W{1'b0}};
      addr_r  <= {SRAM_ADDR_WIDTH{1'b0}};
      pack_r  <= {SRAM_DATA_WIDTH{1'b0}};
      ready_r <= 1'b0;
      req_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == COLLECT);
      req_r   <= (state_nxt_s == WRITE);
      done_r  <= (state_nxt_s == DONE);
      if (launch_s) begin
        addr_r <= waddr_i;
        beat_r <= {CNT_W{1'b0}};
      end else if (beat_acc_s) begin
        pack_r[int'(beat_r)*EXEC_UNIT_DATA_WIDTH +: EXEC_UNIT_DATA_WIDTH] <= result_data_i;
        beat_r <= (beat_r == LAST_BEAT) ? {CNT_W{1'b0}} : beat_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        beat_r <= beat_r;
      end
    end
  end

  assign result_ready_o = ready_r;
  assign wr_req_o       = req_r;
  assign wr_addr_o      = addr_r;
  assign wr_data_o      = pack_r;
  assign done_o         = done_r;

endmodule

// File: tb/tb_vpu_dst_port.sv
// Bench for vpu_dst_port: directed scenarios plus randomized instructions checked
// against a transaction-level expectation of the packed word, address and timing.
module tb_vpu_dst_port;

  localparam int W   = 256;
  localparam int CNT = 2;
  localparam int DW  = 512;
  localparam int AW  = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          wvalid_i = 1'b0;
  logic [AW-1:0] waddr_i = '0;
  logic          result_valid_i = 1'b0;
  logic [W-1:0]  result_data_i = '0;
  logic          result_ready_o;
  logic          wr_req_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          wr_gnt_i = 1'b0;
  logic          done_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vpu_dst_port #(
    .EXEC_UNIT_DATA_WIDTH(W),
    .EXEC_CNT(CNT),
    .SRAM_DATA_WIDTH(DW),
    .SRAM_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start_i),
    .wvalid_i(wvalid_i),
    .waddr_i(waddr_i),
    .result_valid_i(result_valid_i),
    .result_data_i(result_data_i),
    .result_ready_o(result_ready_o),
    .wr_req_o(wr_req_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .wr_gnt_i(wr_gnt_i),
    .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_beat();
    logic [W-1:0] v;
    for (int i = 0; i < W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, result_ready_o, 1'b0);
    chk({tag, "_req"},   wr_req_o,       1'b0);
    chk({tag, "_addr"},  wr_addr_o,      '0);
    chk({tag, "_data"},  wr_data_o,      '0);
    chk({tag, "_done"},  done_o,         1'b0);
  endtask

  // One instruction: gap idle cycles before beat 1, grant withheld gdelay cycles.
  task automatic run_instr(input logic [AW-1:0] a, input bit wv, input logic [W-1:0] b0,
                           input logic [W-1:0] b1, input int gap, input int gdelay,
                           input bit mid_start);
    logic [W-1:0]  beats [CNT];
    logic [DW-1:0] exp_word;
    beats[0] = b0;
    beats[1] = b1;
    exp_word = '0;
    for (int i = 0; i < CNT; i++) exp_word = exp_word | (DW'(beats[i]) << (i*W));

    start_i = 1'b1; wvalid_i = wv; waddr_i = a; result_valid_i = 1'b0;
    wr_gnt_i = 1'($urandom_range(0, 1));
    tick;
    start_i = 1'b0; waddr_i = ~a; wvalid_i = 1'($urandom_range(0, 1));

    if (!wv) begin
      chk("nowr_done",  done_o,         1'b1);
      chk("nowr_req",   wr_req_o,       1'b0);
      chk("nowr_ready", result_ready_o, 1'b0);
      start_i = 1'b1; result_valid_i = 1'b1;
      tick;
      start_i = 1'b0; result_valid_i = 1'b0;
      chk("nowr_done_end", done_o,         1'b0);
      chk("nowr_ready2",   result_ready_o, 1'b0);
      tick;
      chk("nowr_no_restart", done_o,         1'b0);
      chk("nowr_ready3",     result_ready_o, 1'b0);
      chk("nowr_req3",       wr_req_o,       1'b0);
      wr_gnt_i = 1'b0;
      return;
    end

    chk("col_ready", result_ready_o, 1'b1);
    for (int i = 0; i < CNT; i++) begin
      for (int g = 0; g < ((i == 1) ? gap : 0); g++) begin
        result_valid_i = 1'b0; result_data_i = rnd_beat();
        start_i = mid_start && (g == 0); waddr_i = ~a; wvalid_i = 1'b1;
        tick;
        start_i = 1'b0;
        chk("gap_ready", result_ready_o, 1'b1);
        chk("gap_req",   wr_req_o,       1'b0);
      end
      result_valid_i = 1'b1; result_data_i = beats[i];
      tick;
      result_valid_i = 1'b0; result_data_i = rnd_beat();
      if (i < CNT-1) chk("beat_ready", result_ready_o, 1'b1);
    end

    for (int d = 0; d <= gdelay; d++) begin
      chk("wr_req",   wr_req_o,       1'b1);
      chk("wr_addr",  wr_addr_o,      a);
      chk("wr_data",  wr_data_o,      exp_word);
      chk("wr_ready", result_ready_o, 1'b0);
      chk("wr_done",  done_o,         1'b0);
      result_valid_i = 1'($urandom_range(0, 1)); result_data_i = rnd_beat();
      wr_gnt_i = (d == gdelay);
      tick;
    end
    result_valid_i = 1'b0;
    wr_gnt_i = 1'($urandom_range(0, 1));
    chk("done_pulse", done_o,         1'b1);
    chk("done_req",   wr_req_o,       1'b0);
    chk("done_ready", result_ready_o, 1'b0);
    tick;
    chk("done_end", done_o,   1'b0);
    chk("idle_req", wr_req_o, 1'b0);
    wr_gnt_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) tick;
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick;
    chk("post_reset_ready", result_ready_o, 1'b0);
    chk("post_reset_done",  done_o,         1'b0);

    run_instr(10'h005, 1'b1, {32{8'hAA}}, {32{8'hBB}}, 0, 0, 1'b0);
    run_instr(10'h0C3, 1'b0, rnd_beat(), rnd_beat(), 0, 0, 1'b0);
    run_instr(10'h1A7, 1'b1, rnd_beat(), rnd_beat(), 0, 4, 1'b0);
    run_instr(10'h2B4, 1'b1, rnd_beat(), rnd_beat(), 3, 0, 1'b1);

    // Reset while the write waits for a grant: no write may follow.
    start_i = 1'b1; wvalid_i = 1'b1; waddr_i = 10'h123;
    tick;
    start_i = 1'b0;
    for (int i = 0; i < CNT; i++) begin
      result_valid_i = 1'b1; result_data_i = rnd_beat();
      tick;
    end
    result_valid_i = 1'b0; wr_gnt_i = 1'b0;
    chk("abort_wr_pending", wr_req_o, 1'b1);
    rst_n = 1'b0;
    tick;
    chk_all_zero("abort_wr");
    rst_n = 1'b1; wr_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_wr_req",  wr_req_o, 1'b0);
      chk("abort_wr_done", done_o,   1'b0);
    end
    wr_gnt_i = 1'b0;

    // Reset mid-collection: remaining beats are ignored.
    start_i = 1'b1; wvalid_i = 1'b1; waddr_i = 10'h0F0;
    tick;
    start_i = 1'b0; result_valid_i = 1'b1; result_data_i = rnd_beat();
    tick;
    rst_n = 1'b0;
    tick;
    chk_all_zero("abort_col");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      result_data_i = rnd_beat();
      tick;
      chk("abort_col_ready", result_ready_o, 1'b0);
      chk("abort_col_req",   wr_req_o,       1'b0);
    end
    result_valid_i = 1'b0;

    run_instr(10'h3FF, 1'b1, rnd_beat(), rnd_beat(), 1, 2, 1'b0);

    for (int n = 0; n < 24; n++) begin
      run_instr(AW'($urandom), ($urandom_range(0, 3) != 0), rnd_beat(), rnd_beat(),
                $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) tick;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
